// File: rtl/session_ctrl.sv
// Session sequencer for the countdown timer, fan and light: start/pause/cancel FSM, timer prescaler, fan dwell.
// Optional SESSION_CTRL_SOFTSTART_EN: fan moves one speed step per permitted change instead of jumping.
module session_ctrl #(
  parameter int TICK_DIV = 50,
  parameter int HOLD     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic       tmr_zero,
  input  logic [1:0] fan_req,
  output logic       tmr_set,
  output logic       tmr_en,
  output logic       light,
  output logic [1:0] fan,
  output logic [1:0] state,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  HOLD_L    = 8'(HOLD);

  state_t      st_q, st_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [1:0]  fan_q, fan_d;
  logic        done_q, done_d;

  function automatic logic [7:0] hcnt_sat_inc(input logic [7:0] v);
    return (v >= HOLD_L) ? HOLD_L : v + 8'd1;
  endfunction

  // Speed the fan moves to when a change is permitted (also used for the engage from 0).
  function automatic logic [1:0] fan_next(input logic [1:0] cur, input logic [1:0] req);
`ifdef SESSION_CTRL_SOFTSTART_EN
    if (req > cur)      return cur + 2'd1;
    else if (req < cur) return cur - 2'd1;
    else                return cur;
`else
    return (cur == req) ? cur : req;
`endif
  endfunction

  assign tmr_set = (st_q == LOAD);
  assign tmr_en  = (st_q == RUN) && (presc_q == PRESC_MAX) && !tmr_zero;
  assign light   = (st_q == RUN) || (st_q == PAUSE);
  assign fan     = fan_q;
  assign state   = st_q;
  assign done    = done_q;

  always_comb begin
    st_d    = st_q;
    presc_d = presc_q;
    hcnt_d  = hcnt_q;
    fan_d   = 2'd0;
    done_d  = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) st_d = LOAD;
      end
      LOAD: begin
        presc_d = '0;
        hcnt_d  = '0;
        st_d    = cancel ? IDLE : RUN;
      end
      RUN: begin
        // cancel outranks expiry so an aborted session never reports done
        if (cancel) begin
          st_d = IDLE;
        end else if (tmr_zero) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end else if (pause) begin
          st_d = PAUSE;
        end
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 16'd1;
        fan_d   = fan_q;
        if (tmr_en) hcnt_d = hcnt_sat_inc(hcnt_q);
        if (fan_q == 2'd0) begin
          fan_d  = fan_next(fan_q, fan_req);
          hcnt_d = '0;
        end else if ((fan_req != fan_q) && (hcnt_q >= HOLD_L)) begin
          fan_d  = fan_next(fan_q, fan_req);
          hcnt_d = '0;
        end
        if (st_d != RUN) fan_d = 2'd0;
      end
      PAUSE: begin
        if (cancel)     st_d = IDLE;
        else if (start) st_d = RUN;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      presc_q <= '0;
      hcnt_q  <= '0;
      fan_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      presc_q <= presc_d;
      hcnt_q  <= hcnt_d;
      fan_q   <= fan_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_session_ctrl.sv
// Bench for session_ctrl (TICK_DIV=4, HOLD=2) with a step-count timer model driving tmr_zero.
module tb_session_ctrl;
  localparam int TD = 4;
  localparam int HD = 2;
`ifdef SESSION_CTRL_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, pause, cancel, tmr_zero;
  logic [1:0] fan_req;
  logic       tmr_set, tmr_en, light, done;
  logic [1:0] fan, state;

  session_ctrl #(.TICK_DIV(TD), .HOLD(HD)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .cancel(cancel),
    .tmr_zero(tmr_zero), .fan_req(fan_req), .tmr_set(tmr_set), .tmr_en(tmr_en),
    .light(light), .fan(fan), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Timer model: loads on tmr_set, counts down one step per tmr_en, never reset.
  int preset_val = 0;
  int tcnt = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tmr_set) tcnt <= preset_val;
    else if (tmr_en && tcnt > 0) tcnt <= tcnt - 1;
  end
  assign tmr_zero = (tcnt == 0);

  int tests = 0;
  int fails = 0;
  int n_en = 0, n_set = 0, n_done = 0;
  int exp_done_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: counts strobes and pops the expected done cycle on each done pulse.
  always @(negedge clk) begin
    if (tmr_en === 1'b1) n_en++;
    if (tmr_set === 1'b1) n_set++;
    if (done === 1'b1) begin
      n_done++;
      if (exp_done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: done pulse at cycle %0d, none expected", cyc);
      end else begin
        check("done_cycle", cyc, exp_done_q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    int         preset;
    int         start_len;
    int         cmd_at;
    logic [2:0] cmd;       // {start,pause,cancel} forced at cmd_at
    int         exp_en;
    int         exp_set;
    int         exp_done;
    string      name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int e0, s0, d0, c, t_hold;
    bit ended;

    vecs[0] = '{3, 1, 0, 3'b000, 3, 1, 1, "basic3"};
    vecs[1] = '{0, 1, 0, 3'b000, 0, 1, 1, "zero_preset"};
    vecs[2] = '{2, 1, 0, 3'b000, 2, 1, 1, "basic2"};
    vecs[3] = '{3, 1, 6, 3'b001, 1, 1, 0, "cancel_run"};
    vecs[4] = '{3, 1, 1, 3'b001, 0, 1, 0, "cancel_load"};
    vecs[5] = '{1, 1, 6, 3'b001, 1, 1, 0, "cancel_with_zero"};
    vecs[6] = '{1, 1, 6, 3'b010, 1, 1, 1, "pause_with_zero"};
    vecs[7] = '{2, 1, 3, 3'b111, 0, 1, 0, "all_three_cmds"};
    vecs[8] = '{2, 3, 0, 3'b000, 2, 1, 1, "held_start"};

    rst = 1'b1; start = 1'b0; pause = 1'b0; cancel = 1'b0; fan_req = 2'd0;
    step(); step();
    check("rst_state", int'(state), 0);
    check("rst_tmr_set", int'(tmr_set), 0);
    check("rst_tmr_en", int'(tmr_en), 0);
    check("rst_light", int'(light), 0);
    check("rst_fan", int'(fan), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    step();

    foreach (vecs[k]) begin
      preset_val = vecs[k].preset;
      e0 = n_en; s0 = n_set; d0 = n_done;
      c = cyc;
      if (vecs[k].exp_done != 0) exp_done_q.push_back(c + 3 + TD * vecs[k].preset);
      ended = 1'b0;
      for (int i = 0; i < 300; i++) begin
        start  = (i < vecs[k].start_len);
        pause  = 1'b0;
        cancel = 1'b0;
        if (vecs[k].cmd != 3'b000 && i == vecs[k].cmd_at) begin
          start  = vecs[k].cmd[2];
          pause  = vecs[k].cmd[1];
          cancel = vecs[k].cmd[0];
        end
        step();
        if (i >= 1 && state == 2'd0) begin
          ended = 1'b1;
          break;
        end
      end
      start = 1'b0; pause = 1'b0; cancel = 1'b0;
      if (!ended) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: session still in state %0d, required IDLE", vecs[k].name, state);
      end
      check({vecs[k].name, "_light_off"}, int'(light), 0);
      step(); step();
      check({vecs[k].name, "_tmr_en_count"}, n_en - e0, vecs[k].exp_en);
      check({vecs[k].name, "_tmr_set_count"}, n_set - s0, vecs[k].exp_set);
      check({vecs[k].name, "_done_count"}, n_done - d0, vecs[k].exp_done);
    end

    // Pause mid-step after two count steps, hold 20 cycles, resume without reload.
    preset_val = 60;
    e0 = n_en;
    start = 1'b1; step(); start = 1'b0;
    check("pause_load_strobe", int'(tmr_set), 1);
    repeat (10) step();
    check("pause_pre_state", int'(state), 2);
    check("pause_pre_light", int'(light), 1);
    pause = 1'b1; step(); pause = 1'b0;
    check("pause_pre_en_count", n_en - e0, 2);
    check("pause_state", int'(state), 3);
    check("pause_light", int'(light), 1);
    check("pause_fan", int'(fan), 0);
    t_hold = tcnt;
    check("pause_timer_val", t_hold, 58);
    for (int i = 0; i < 20; i++) begin
      step();
      check("pause_hold_state", int'(state), 3);
      check("pause_hold_tmr_en", int'(tmr_en), 0);
    end
    check("pause_timer_frozen", tcnt, 58);
    start = 1'b1; step(); start = 1'b0;
    check("resume_state", int'(state), 2);
    check("resume_tmr_set", int'(tmr_set), 0);
    check("resume_first_en", int'(tmr_en), 0);
    step();
    check("resume_second_en", int'(tmr_en), 1);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("resume_cancel_state", int'(state), 0);
    check("resume_cancel_light", int'(light), 0);
    step();

    // Fan dwell: engage at 1, request 3 after the first step, then reset mid-run.
    preset_val = 10;
    fan_req = 2'd1;
    start = 1'b1; step(); start = 1'b0;
    step();
    check("fan_r1", int'(fan), 0);
    step();
    check("fan_r2_engaged", int'(fan), 1);
    repeat (3) step();
    fan_req = 2'd3;
    repeat (4) step();
    check("fan_r9_dwell", int'(fan), 1);
    step();
    check("fan_r10_change", int'(fan), SOFT ? 2 : 3);
    repeat (7) step();
    check("fan_r17", int'(fan), SOFT ? 2 : 3);
    step();
    check("fan_r18", int'(fan), 3);
    check("fan_r18_light", int'(light), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_state", int'(state), 0);
    check("midrst_tmr_set", int'(tmr_set), 0);
    check("midrst_tmr_en", int'(tmr_en), 0);
    check("midrst_light", int'(light), 0);
    check("midrst_fan", int'(fan), 0);
    check("midrst_done", int'(done), 0);
    fan_req = 2'd0;
    step(); step();

    check("sb_pending_done", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
